display_scan: RTL and testbench

Time-multiplexed seven-segment display driver that directly consumes the divided clock produced by the clock-divider stage. It uses that clock only as a level signal: the block samples it in the fast system clock domain and edge-detects it, so the design has one clock. On each rising edge of the divided clock the block advances to the next digit. It drives active-low anode, segment and decimal-point lines for an N-digit common-anode display, with a programmable blanking gap to suppress ghosting.

---
 rtl/display_scan.sv | 180 ++++++++++++++++++
 tb/tb_display_scan.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/display_scan.sv
// Time-multiplexed seven-segment scanner for an N-digit common-anode display.
// Steps on rising edges of a divided tick sampled in the clk_in domain, with an optional dark gap.
module display_scan #(
    parameter int N_DIGITS     = 8,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  tick_in,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_mask,
    input  logic [N_DIGITS-1:0]   blank_mask,
    output logic [N_DIGITS-1:0]   an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int IW      = $clog2(N_DIGITS);
    localparam int CW      = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam int GAP_INT = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_DIGITS - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_INT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    // With no gap configured a step lands straight in SHOW.
    localparam state_t STEP_STATE = (BLANK_CYCLES > 0) ? BLANK : SHOW;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = 7'b1000000;
            4'h1: hex_to_seg = 7'b1111001;
            4'h2: hex_to_seg = 7'b0100100;
            4'h3: hex_to_seg = 7'b0110000;
            4'h4: hex_to_seg = 7'b0011001;
            4'h5: hex_to_seg = 7'b0010010;
            4'h6: hex_to_seg = 7'b0000010;
            4'h7: hex_to_seg = 7'b1111000;
            4'h8: hex_to_seg = 7'b0000000;
            4'h9: hex_to_seg = 7'b0010000;
            4'hA: hex_to_seg = 7'b0001000;
            4'hB: hex_to_seg = 7'b0000011;
            4'hC: hex_to_seg = 7'b1000110;
            4'hD: hex_to_seg = 7'b0100001;
            4'hE: hex_to_seg = 7'b0000110;
            4'hF: hex_to_seg = 7'b0001110;
            default: hex_to_seg = 7'b1111111;
        endcase
    endfunction

    state_t                state_r, state_s;
    logic                  tick_q_r;
    logic                  step_s, advance_s;
    logic [IW-1:0]         idx_r, idx_s, next_idx_s;
    logic [CW-1:0]         cnt_r, cnt_s;
    logic [4*N_DIGITS-1:0] value_snap_r, value_snap_s;
    logic [N_DIGITS-1:0]   dp_snap_r, dp_snap_s;
    logic [N_DIGITS-1:0]   blank_snap_r, blank_snap_s;
    logic [N_DIGITS-1:0]   an_r, an_s;
    logic [6:0]            seg_r, seg_s;
    logic                  dp_r, dp_s;

    // Next-state, index/gap counter, snapshot and output-pattern logic.
    always_comb begin
        step_s       = tick_in & ~tick_q_r;
        state_s      = state_r;
        idx_s        = idx_r;
        cnt_s        = cnt_r;
        value_snap_s = value_snap_r;
        dp_snap_s    = dp_snap_r;
        blank_snap_s = blank_snap_r;
        advance_s    = 1'b0;
        seg_s        = seg_r;
        dp_s         = dp_r;
        an_s         = {N_DIGITS{1'b1}};

        if (idx_r == LAST_IDX) begin
            next_idx_s = {IW{1'b0}};
        end else begin
            next_idx_s = idx_r + IW'(1);
        end

        case (state_r)
            IDLE: begin
                if (step_s) begin
                    idx_s     = {IW{1'b0}};
                    advance_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            BLANK: begin
                if (step_s) begin
                    idx_s     = next_idx_s;
                    advance_s = 1'b1;
                end else if (cnt_r == {CW{1'b0}}) begin
                    state_s = SHOW;
                end else begin
                    cnt_s = cnt_r - CW'(1);
                end
            end
            SHOW: begin
                if (step_s) begin
                    idx_s     = next_idx_s;
                    advance_s = 1'b1;
                end else begin
                    state_s = SHOW;
                end
            end
            default: begin
                state_s = IDLE;
                idx_s   = {IW{1'b0}};
            end
        endcase

        // A frame only takes fresh inputs when it restarts at digit 0, so it never tears.
        if (advance_s) begin
            state_s = STEP_STATE;
            cnt_s   = GAP_LOAD;
            if (idx_s == {IW{1'b0}}) begin
                value_snap_s = value;
                dp_snap_s    = dp_mask;
                blank_snap_s = blank_mask;
            end else begin
                value_snap_s = value_snap_r;
            end
            if (blank_snap_s[idx_s]) begin
                seg_s = 7'b1111111;
                dp_s  = 1'b1;
            end else begin
                seg_s = hex_to_seg(value_snap_s[{idx_s, 2'b00} +: 4]);
                dp_s  = ~dp_snap_s[idx_s];
            end
        end else begin
            seg_s = seg_r;
        end

        if ((state_s == SHOW) && !blank_snap_s[idx_s]) begin
            an_s[idx_s] = 1'b0;
        end else begin
            an_s = {N_DIGITS{1'b1}};
        end
    end

    // State, snapshot and registered output update.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            tick_q_r     <= 1'b0;
            idx_r        <= {IW{1'b0}};
            cnt_r        <= {CW{1'b0}};
            value_snap_r <= {(4*N_DIGITS){1'b0}};
            dp_snap_r    <= {N_DIGITS{1'b0}};
            blank_snap_r <= {N_DIGITS{1'b0}};
            an_r         <= {N_DIGITS{1'b1}};
            seg_r        <= 7'b1111111;
            dp_r         <= 1'b1;
        end else begin
            state_r      <= state_s;
            tick_q_r     <= tick_in;
            idx_r        <= idx_s;
            cnt_r        <= cnt_s;
            value_snap_r <= value_snap_s;
            dp_snap_r    <= dp_snap_s;
            blank_snap_r <= blank_snap_s;
            an_r         <= an_s;
            seg_r        <= seg_s;
            dp_r         <= dp_s;
        end
    end

    assign an  = an_r;
    assign seg = seg_r;
    assign dp  = dp_r;

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan: table of scan steps with a scoreboard queue,
// plus hand-written sequences for held tick, step during the gap and mid-frame reset.
module tb_display_scan;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    typedef struct {
        logic [31:0] value;
        logic [7:0]  dpm;
        logic [7:0]  blm;
        exp_t        e;
    } vec_t;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b1;
    logic        tick_in = 1'b0;
    logic [31:0] value = 32'h0;
    logic [7:0]  dp_mask = 8'h00;
    logic [7:0]  blank_mask = 8'h00;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t exp_q[$];

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    vec_t vecs [20];
    vec_t tail [5];

    display_scan #(.N_DIGITS(8), .BLANK_CYCLES(4)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .tick_in    (tick_in),
        .value      (value),
        .dp_mask    (dp_mask),
        .blank_mask (blank_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input logic [31:0] v, input logic [7:0] dpm, input logic [7:0] blm,
                                input logic [7:0] a, input logic [6:0] s, input logic d);
        vec_t r;
        r.value = v; r.dpm = dpm; r.blm = blm;
        r.e.an = a; r.e.seg = s; r.e.dp = d;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // Called at the falling edge right after a step edge; pops the expected digit.
    task automatic check_slot(input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_queue: got 0 entries expected 1", name);
            return;
        end
        e = exp_q.pop_front();
        chk({name, "_seg"}, {25'd0, seg}, {25'd0, e.seg});
        chk({name, "_dp"}, {31'd0, dp}, {31'd0, e.dp});
        for (int k = 0; k < 4; k++) begin
            chk({name, "_an_gap"}, {24'd0, an}, 32'h0000_00FF);
            @(negedge clk_in);
        end
        chk({name, "_an_show"}, {24'd0, an}, {24'd0, e.an});
        repeat (15) @(negedge clk_in);
        chk({name, "_an_hold"}, {24'd0, an}, {24'd0, e.an});
        chk({name, "_seg_hold"}, {25'd0, seg}, {25'd0, e.seg});
    endtask

    task automatic pulse_step;
        tick_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        tick_in = 1'b0;
    endtask

    initial begin
        exp_t e;
        vecs[0]  = mk(32'h76543210, 8'h00, 8'h00, 8'hFE, seg_tab[0], 1'b1);
        vecs[1]  = mk(32'h76543210, 8'h00, 8'h00, 8'hFD, seg_tab[1], 1'b1);
        vecs[2]  = mk(32'h76543210, 8'h00, 8'h00, 8'hFB, seg_tab[2], 1'b1);
        vecs[3]  = mk(32'h76543210, 8'h00, 8'h00, 8'hF7, seg_tab[3], 1'b1);
        vecs[4]  = mk(32'hFFFFFFFF, 8'h00, 8'h00, 8'hEF, seg_tab[4], 1'b1);
        vecs[5]  = mk(32'hFFFFFFFF, 8'h00, 8'h00, 8'hDF, seg_tab[5], 1'b1);
        vecs[6]  = mk(32'hFFFFFFFF, 8'h00, 8'h00, 8'hBF, seg_tab[6], 1'b1);
        vecs[7]  = mk(32'hFFFFFFFF, 8'h00, 8'h00, 8'h7F, seg_tab[7], 1'b1);
        vecs[8]  = mk(32'hFFFFFFFF, 8'h00, 8'h00, 8'hFE, seg_tab[15], 1'b1);
        vecs[9]  = mk(32'h01234567, 8'h01, 8'h02, 8'hFD, seg_tab[15], 1'b1);
        vecs[10] = mk(32'h01234567, 8'h01, 8'h02, 8'hFB, seg_tab[15], 1'b1);
        vecs[11] = mk(32'h01234567, 8'h01, 8'h02, 8'hF7, seg_tab[15], 1'b1);
        vecs[12] = mk(32'h01234567, 8'h01, 8'h02, 8'hEF, seg_tab[15], 1'b1);
        vecs[13] = mk(32'h01234567, 8'h01, 8'h02, 8'hDF, seg_tab[15], 1'b1);
        vecs[14] = mk(32'h01234567, 8'h01, 8'h02, 8'hBF, seg_tab[15], 1'b1);
        vecs[15] = mk(32'h01234567, 8'h01, 8'h02, 8'h7F, seg_tab[15], 1'b1);
        vecs[16] = mk(32'h01234567, 8'h01, 8'h02, 8'hFE, seg_tab[7], 1'b0);
        vecs[17] = mk(32'h01234567, 8'h01, 8'h02, 8'hFF, 7'h7F, 1'b1);
        vecs[18] = mk(32'h01234567, 8'h01, 8'h02, 8'hFB, seg_tab[5], 1'b1);
        vecs[19] = mk(32'h01234567, 8'h01, 8'h02, 8'hF7, seg_tab[4], 1'b1);
        tail[0]  = mk(32'h01234567, 8'h01, 8'h02, 8'h7F, seg_tab[0], 1'b1);
        tail[1]  = mk(32'h01234567, 8'h01, 8'h02, 8'hFE, seg_tab[7], 1'b0);
        tail[2]  = mk(32'h01234567, 8'h01, 8'h02, 8'hFF, 7'h7F, 1'b1);
        tail[3]  = mk(32'h01234567, 8'h01, 8'h02, 8'hFB, seg_tab[5], 1'b1);
        tail[4]  = mk(32'h01234567, 8'h01, 8'h02, 8'hF7, seg_tab[4], 1'b1);

        // Asynchronous reset before any clock edge.
        #2 reset = 1'b0;
        #1;
        chk("rst_an", {24'd0, an}, 32'h0000_00FF);
        chk("rst_seg", {25'd0, seg}, 32'h0000_007F);
        chk("rst_dp", {31'd0, dp}, 32'h1);
        repeat (3) @(negedge clk_in);
        reset = 1'b1;
        repeat (10) @(negedge clk_in);
        chk("idle_an", {24'd0, an}, 32'h0000_00FF);
        chk("idle_seg", {25'd0, seg}, 32'h0000_007F);
        chk("idle_dp", {31'd0, dp}, 32'h1);

        // Full scan, frame snapshot, blank and dp table.
        for (int i = 0; i < 20; i++) begin
            value      = vecs[i].value;
            dp_mask    = vecs[i].dpm;
            blank_mask = vecs[i].blm;
            exp_q.push_back(vecs[i].e);
            pulse_step();
            check_slot($sformatf("vec%0d", i));
        end

        // Tick held high for 100 cycles: one step, digit 3 -> 4.
        e.an = 8'hEF; e.seg = seg_tab[3]; e.dp = 1'b1;
        exp_q.push_back(e);
        tick_in = 1'b1;
        repeat (100) @(negedge clk_in);
        e = exp_q.pop_front();
        chk("held_an", {24'd0, an}, {24'd0, e.an});
        chk("held_seg", {25'd0, seg}, {25'd0, e.seg});
        tick_in = 1'b0;
        @(negedge clk_in);

        // Second rise inside the gap: digit 5 is skipped dark, gap restarts for digit 6.
        e.an = 8'hBF; e.seg = seg_tab[1]; e.dp = 1'b1;
        exp_q.push_back(e);
        pulse_step();
        chk("gap_an_k0", {24'd0, an}, 32'h0000_00FF);
        chk("gap_seg_k0", {25'd0, seg}, {25'd0, seg_tab[2]});
        @(negedge clk_in);
        chk("gap_an_k1", {24'd0, an}, 32'h0000_00FF);
        pulse_step();
        check_slot("gap_step");

        // Walk on to digit 3 through the wrap.
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(tail[i].e);
            pulse_step();
            check_slot($sformatf("tail%0d", i));
        end

        // Reset mid-frame takes effect between clock edges.
        chk("pre_reset_an", {24'd0, an}, 32'h0000_00F7);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_an", {24'd0, an}, 32'h0000_00FF);
        chk("mid_rst_seg", {25'd0, seg}, 32'h0000_007F);
        chk("mid_rst_dp", {31'd0, dp}, 32'h1);
        value      = 32'h76543210;
        dp_mask    = 8'h00;
        blank_mask = 8'h00;
        tick_in    = 1'b1;
        repeat (2) @(negedge clk_in);
        // Tick already high at release: the first edge is a step to digit 0.
        e.an = 8'hFE; e.seg = seg_tab[0]; e.dp = 1'b1;
        exp_q.push_back(e);
        reset = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        tick_in = 1'b0;
        check_slot("post_rst");

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
